// File: rtl/clk_std_sequencer.sv
// clk_std_sequencer
//
// Sequences a video-standard (PAL/NTSC) colour-clock switchover together
// with the system reset.  A standard change holds the system in reset,
// resets the clock generators while the BUFGMUX select moves, waits for
// the PLLs to lock and settle, and only then releases the system reset.
// The block runs on the free-running PAL colour clock, so it keeps
// running while the mux output is switching.
//
// Ports:
//   clk_col4x_pal  in   free-running PAL 4x colour clock (only clock)
//   rst_n          in   asynchronous active-low reset
//   std_req        in   requested standard, 1 = PAL (asynchronous)
//   pll_locked     in   clock generator lock (asynchronous)
//   mux_sel        out  BUFGMUX select, 1 = PAL
//   pll_reset      out  active-high reset to the clock generators
//   sys_rst        out  active-high reset to vicii / cpu
//   busy           out  high in every state except RUN
//   lock_fail      out  sticky lock-timeout flag, cleared only by rst_n
module clk_std_sequencer #(
    parameter int FILTER_CYCLES = 16,
    parameter int PRE_CYCLES    = 64,
    parameter int POST_CYCLES   = 1024,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic clk_col4x_pal,
    input  logic rst_n,
    input  logic std_req,
    input  logic pll_locked,
    output logic mux_sel,
    output logic pll_reset,
    output logic sys_rst,
    output logic busy,
    output logic lock_fail
);

    // Hold states exit when the count reaches N-1, so each lasts N cycles.
    localparam logic [15:0] FILTER_LAST  = 16'(FILTER_CYCLES - 1);
    localparam logic [15:0] PRE_LAST     = 16'(PRE_CYCLES - 1);
    localparam logic [15:0] POST_LAST    = 16'(POST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_QUIESCE,
        ST_SWITCH,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  req_sync_q, req_sync_d;
    logic [1:0]  lock_sync_q, lock_sync_d;
    logic        first_q, first_d;
    logic        mux_sel_q, mux_sel_d;
    logic        pll_reset_q, pll_reset_d;
    logic        sys_rst_q, sys_rst_d;
    logic        busy_q, busy_d;
    logic        lock_fail_q, lock_fail_d;

    logic        req_s;
    logic        lock_s;

    assign req_s  = req_sync_q[1];
    assign lock_s = lock_sync_q[1];

    always_ff @(posedge clk_col4x_pal or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SWITCH;
            count_q     <= 16'd0;
            req_sync_q  <= 2'b00;
            lock_sync_q <= 2'b00;
            first_q     <= 1'b1;
            mux_sel_q   <= 1'b1;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            busy_q      <= 1'b1;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            req_sync_q  <= req_sync_d;
            lock_sync_q <= lock_sync_d;
            first_q     <= first_d;
            mux_sel_q   <= mux_sel_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            busy_q      <= busy_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q + 16'd1;
        req_sync_d  = {req_sync_q[0], std_req};
        lock_sync_d = {lock_sync_q[0], pll_locked};
        first_d     = 1'b0;
        mux_sel_d   = mux_sel_q;
        lock_fail_d = lock_fail_q;

        case (state_q)
            ST_SWITCH: begin
                if (count_q == PRE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_SETTLE;
                end else if (count_q == TIMEOUT_LAST) begin
                    lock_fail_d = 1'b1;
                    state_d     = ST_SWITCH;
                end
            end
            ST_SETTLE: begin
                // Lock must hold for POST_CYCLES consecutive cycles; a drop
                // on the final cycle still sends us back to WAIT_LOCK.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (count_q == POST_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The count doubles as the request mismatch filter here.
                // Lock loss wins over the filter.
                if (!lock_s) begin
                    state_d = ST_QUIESCE;
                end else if (req_s != mux_sel_q) begin
                    if (count_q == FILTER_LAST) begin
                        state_d = ST_QUIESCE;
                    end
                end else begin
                    count_d = 16'd0;
                end
            end
            ST_QUIESCE: begin
                if (count_q == PRE_LAST) begin
                    state_d = ST_SWITCH;
                end
            end
            default: begin
                state_d = ST_SWITCH;
            end
        endcase

        if (state_d != state_q) begin
            count_d = 16'd0;
        end

        // The select only moves on SWITCH entry (and on the first clock out
        // of reset, which is treated as one), i.e. only while both the PLLs
        // and the system are held in reset.
        if (first_q || (state_d == ST_SWITCH && state_q != ST_SWITCH)) begin
            mux_sel_d = req_s;
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        pll_reset_d = (state_d == ST_SWITCH);
        sys_rst_d   = (state_d != ST_RUN);
        busy_d      = (state_d != ST_RUN);
    end

    assign mux_sel   = mux_sel_q;
    assign pll_reset = pll_reset_q;
    assign sys_rst   = sys_rst_q;
    assign busy      = busy_q;
    assign lock_fail = lock_fail_q;

endmodule

// File: tb/tb_clk_std_sequencer.sv
// Testbench for clk_std_sequencer.
// Stimulus pushes expected output transitions (vector + clock stamp) into a
// queue; a monitor sampling on the falling edge pops and compares every
// time the registered output vector {mux_sel,pll_reset,sys_rst,busy,lock_fail}
// changes.
module tb_clk_std_sequencer;

    logic clk_col4x_pal;
    logic rst_n;
    logic std_req;
    logic pll_locked;
    logic mux_sel;
    logic pll_reset;
    logic sys_rst;
    logic busy;
    logic lock_fail;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [4:0] exp_vec[$];
    int         exp_cyc[$];
    string      exp_name[$];
    logic [4:0] prev_v = 5'bxxxxx;

    clk_std_sequencer #(
        .FILTER_CYCLES(3),
        .PRE_CYCLES   (4),
        .POST_CYCLES  (8),
        .LOCK_TIMEOUT (20)
    ) dut (
        .clk_col4x_pal(clk_col4x_pal),
        .rst_n        (rst_n),
        .std_req      (std_req),
        .pll_locked   (pll_locked),
        .mux_sel      (mux_sel),
        .pll_reset    (pll_reset),
        .sys_rst      (sys_rst),
        .busy         (busy),
        .lock_fail    (lock_fail)
    );

    initial clk_col4x_pal = 1'b0;
    always #5 clk_col4x_pal = ~clk_col4x_pal;

    // cyc = number of rising edges seen so far.
    always @(posedge clk_col4x_pal) cyc <= cyc + 1;

    task automatic push(input logic [4:0] v, input int c, input string n);
        exp_vec.push_back(v);
        exp_cyc.push_back(c);
        exp_name.push_back(n);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_col4x_pal);
    endtask

    // Monitor: one comparison per output-vector change.
    always @(negedge clk_col4x_pal) begin
        logic [4:0] v;
        logic [4:0] ev;
        int         ec;
        string      en;
        v = {mux_sel, pll_reset, sys_rst, busy, lock_fail};
        if (v !== prev_v) begin
            total++;
            if (exp_vec.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got vec=%b at cyc=%0d, required no change", v, cyc);
            end else begin
                ev = exp_vec.pop_front();
                ec = exp_cyc.pop_front();
                en = exp_name.pop_front();
                if (v !== ev || (ec >= 0 && ec != cyc)) begin
                    bad++;
                    $display("FAIL %s: got vec=%b cyc=%0d, required vec=%b cyc=%0d", en, v, cyc, ev, ec);
                end
            end
            prev_v = v;
        end
    end

    initial begin
        int b;
        rst_n      = 1'b1;
        std_req    = 1'b0;
        pll_locked = 1'b0;
        #1 rst_n   = 1'b0;

        // Vector order: {mux_sel, pll_reset, sys_rst, busy, lock_fail}
        push(5'b11110, -1, "reset_state");
        tick(3);

        // Power-up: NTSC requested, lock arrives 10 cycles after release.
        b = cyc;
        rst_n = 1'b1;
        push(5'b01110, b + 1, "pwr_mux_first_edge");
        push(5'b00110, b + 4, "pwr_pll_reset_4cyc");
        tick(10);
        b = cyc;
        pll_locked = 1'b1;
        // 2 sync + 1 WAIT_LOCK detect + 8 SETTLE
        push(5'b00000, b + 11, "pwr_run_entry");
        tick(15);

        // Glitch: 2-cycle pulse never reaches the 3-cycle filter.
        std_req = 1'b1;
        tick(2);
        std_req = 1'b0;
        tick(10);

        // NTSC -> PAL.
        b = cyc;
        std_req = 1'b1;
        push(5'b00110, b + 5,  "pal_quiesce");
        push(5'b11110, b + 9,  "pal_switch_mux");
        push(5'b10110, b + 13, "pal_wait_lock");
        push(5'b10000, b + 22, "pal_run");
        tick(30);

        // PAL -> NTSC with lock loss at SETTLE cycle 5 (SETTLE entered b+14).
        b = cyc;
        std_req = 1'b0;
        push(5'b10110, b + 5,  "ntsc_quiesce");
        push(5'b01110, b + 9,  "ntsc_switch_mux");
        push(5'b00110, b + 13, "ntsc_wait_lock");
        tick(19);
        pll_locked = 1'b0;
        tick(6);
        pll_locked = 1'b1;
        // Full 8-cycle SETTLE after relock: lock back at b+25, RUN at b+36.
        push(5'b00000, b + 36, "settle_full_after_relock");
        tick(15);

        // Lock loss in RUN, then timeout with lock held low.
        b = cyc;
        pll_locked = 1'b0;
        push(5'b00110, b + 3,  "lossrun_quiesce");
        push(5'b01110, b + 7,  "lossrun_switch");
        push(5'b00110, b + 11, "lossrun_wait_lock");
        push(5'b01111, b + 31, "timeout_lock_fail_switch");
        push(5'b00111, b + 35, "timeout_wait_lock");
        tick(40);
        pll_locked = 1'b1;
        push(5'b00001, b + 51, "timeout_run_sticky");
        tick(16);

        // Asynchronous reset while in WAIT_LOCK.
        b = cyc;
        pll_locked = 1'b0;
        push(5'b00111, b + 3,  "rst_quiesce");
        push(5'b01111, b + 7,  "rst_switch");
        push(5'b00111, b + 11, "rst_wait_lock");
        tick(15);
        push(5'b11110, b + 16, "async_reset_event");
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mux_sel, pll_reset, sys_rst, busy, lock_fail} !== 5'b11110) begin
            bad++;
            $display("FAIL async_reset_immediate: got %b, required 11110",
                     {mux_sel, pll_reset, sys_rst, busy, lock_fail});
        end
        tick(3);

        total++;
        if (exp_vec.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d outstanding, required 0", exp_vec.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
